bus_arbiter: RTL and testbench

- Shares one external data/instruction bus (single-port, variable-latency slave with ack) between the fetch port and the load/store port driven by the memory stage.
- Registers each request, drives the bus until ack, buffers the returned word and raises per-port stall requests toward the ctrl block until the result is consumed.
- Sits between if/mem stages and the SoC bus.
- Load/store has priority over fetch.

---
 rtl/bus_arbiter_pkg.sv | 30 +++
 rtl/bus_arbiter_port_buf.sv | 57 +++++
 rtl/bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_bus_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_pkg
// Description : Shared constants and state encoding for the fetch/load-store
//               bus arbiter.
// Contents    : RST_ENABLE, CHIP_ENABLE, WRITE_ENABLE, SEL_WORD,
//               STALL_IF / STALL_MEM stall-vector indices, arb_state_t.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  // Instruction fetches are always full-word reads.
  localparam logic [3:0] SEL_WORD = 4'b1111;

  // Indices into the ctrl stall vector.
  localparam int STALL_IF  = 1;
  localparam int STALL_MEM = 4;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'b00,
    ARB_LS_BUS = 2'b01,
    ARB_IF_BUS = 2'b10
  } arb_state_t;

endpackage : bus_arbiter_pkg
`default_nettype wire

// File: rtl/bus_arbiter_port_buf.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_port_buf
// Description : Result register with valid flag for one arbiter port.
//               Captures the bus read word on ack, keeps it while the owning
//               pipeline stage is held, and releases it when the stage
//               advances or on flush.
// Ports       : clk, rst       - clock, asynchronous active-high reset
//               flush          - drop the buffered result
//               advance        - owning stage moves on this cycle
//               capture        - transfer completed this cycle
//               capture_data   - load the read word (0 for stores)
//               rdata          - bus read data
//               valid, data    - buffered result and its valid flag
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_port_buf
  import bus_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              advance,
  input  logic              capture,
  input  logic              capture_data,
  input  logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  // A capture can only happen while r_valid is 0 (the arbiter never issues
  // for a port holding a result), so capture and release never collide.
  // The data word is never cleared on release; it simply goes stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (capture) begin
      r_valid <= 1'b1;
      if (capture_data) begin
        r_data <= rdata;
      end
    end else if (r_valid && (advance || flush)) begin
      r_valid <= 1'b0;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule : bus_arbiter_port_buf
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter
// Description : Shares one single-port, variable-latency bus between the
//               instruction fetch port and the load/store port. Load/store
//               wins over fetch. Each request is registered onto the bus,
//               held until ack, and the result buffered until the stage
//               consumes it; stall requests go to ctrl meanwhile.
// Ports       : clk, rst                 - clock, async active-high reset
//               stall_i[5:0], flush_i    - pipeline control from ctrl
//               if_ce_i, if_addr_i       - fetch request
//               if_data_o, if_stallreq_o - fetch result / stall request
//               ls_ce_i, ls_we_i, ls_addr_i, ls_sel_i, ls_data_i
//                                        - load/store request
//               ls_data_o, ls_stallreq_o - load result / stall request
//               bus_*                    - shared bus master interface
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall_i,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_data_o,
  output logic              if_stallreq_o,
  input  logic              ls_ce_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [3:0]        ls_sel_i,
  input  logic [DATA_W-1:0] ls_data_i,
  output logic [DATA_W-1:0] ls_data_o,
  output logic              ls_stallreq_o,
  output logic              bus_cyc_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_data_o,
  input  logic [DATA_W-1:0] bus_data_i,
  input  logic              bus_ack_i
);

  arb_state_t        r_state;
  logic              r_bus_cyc;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [3:0]        r_bus_sel;
  logic [DATA_W-1:0] r_bus_data;
  logic              r_drop;

  logic w_ls_valid;
  logic w_if_valid;
  logic w_ls_done;
  logic w_if_done;
  logic w_if_capture;
  logic w_ls_req;
  logic w_if_req;
  logic w_unused_stall;

  // Only the fetch and mem stage hold bits matter here.
  assign w_unused_stall = ^{stall_i[5], stall_i[3:2], stall_i[0]};

  assign w_ls_req = (ls_ce_i == CHIP_ENABLE) && !w_ls_valid;
  assign w_if_req = (if_ce_i == CHIP_ENABLE) && !w_if_valid;

  assign ls_stallreq_o = w_ls_req;
  assign if_stallreq_o = w_if_req;

  // Ack is only meaningful while a transfer is outstanding.
  assign w_ls_done = (r_state == ARB_LS_BUS) && bus_ack_i;
  assign w_if_done = (r_state == ARB_IF_BUS) && bus_ack_i;

  // A fetch flushed at any point of its flight (including the ack cycle)
  // completes on the bus but its data is thrown away.
  assign w_if_capture = w_if_done && !r_drop && !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      r_state    <= ARB_IDLE;
      r_bus_cyc  <= 1'b0;
      r_bus_we   <= 1'b0;
      r_bus_addr <= '0;
      r_bus_sel  <= 4'b0000;
      r_bus_data <= '0;
      r_drop     <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_ls_req) begin
            r_bus_cyc  <= 1'b1;
            r_bus_we   <= (ls_we_i == WRITE_ENABLE);
            r_bus_addr <= ls_addr_i;
            r_bus_sel  <= ls_sel_i;
            r_bus_data <= ls_data_i;
            r_state    <= ARB_LS_BUS;
          end else if (w_if_req && !flush_i) begin
            // The fetch address presented during a flush is the stale
            // pre-flush PC; wait one cycle for the redirected address.
            r_bus_cyc  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_addr <= if_addr_i;
            r_bus_sel  <= SEL_WORD;
            r_bus_data <= '0;
            r_state    <= ARB_IF_BUS;
          end
        end
        ARB_LS_BUS: begin
          if (bus_ack_i) begin
            r_bus_cyc <= 1'b0;
            r_state   <= ARB_IDLE;
          end
        end
        ARB_IF_BUS: begin
          if (bus_ack_i) begin
            r_bus_cyc <= 1'b0;
            r_drop    <= 1'b0;
            r_state   <= ARB_IDLE;
          end else if (flush_i) begin
            r_drop <= 1'b1;
          end
        end
        default: begin
          r_bus_cyc <= 1'b0;
          r_drop    <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

  bus_arbiter_port_buf #(
    .DATA_W (DATA_W)
  ) u_ls_buf (
    .clk          (clk),
    .rst          (rst),
    .flush        (1'b0),
    .advance      (!stall_i[STALL_MEM]),
    .capture      (w_ls_done),
    .capture_data (!r_bus_we),
    .rdata        (bus_data_i),
    .valid        (w_ls_valid),
    .data         (ls_data_o)
  );

  bus_arbiter_port_buf #(
    .DATA_W (DATA_W)
  ) u_if_buf (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush_i),
    .advance      (!stall_i[STALL_IF]),
    .capture      (w_if_capture),
    .capture_data (1'b1),
    .rdata        (bus_data_i),
    .valid        (w_if_valid),
    .data         (if_data_o)
  );

  assign bus_cyc_o  = r_bus_cyc;
  assign bus_we_o   = r_bus_we;
  assign bus_addr_o = r_bus_addr;
  assign bus_sel_o  = r_bus_sel;
  assign bus_data_o = r_bus_data;

endmodule : bus_arbiter
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter
// Description : Directed self-checking bench for bus_arbiter. Inputs change
//               at the falling clock edge, outputs are checked 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  stall_i = '0;
  logic        flush_i = 1'b0;
  logic        if_ce_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic [31:0] if_data_o;
  logic        if_stallreq_o;
  logic        ls_ce_i = 1'b0;
  logic        ls_we_i = 1'b0;
  logic [31:0] ls_addr_i = '0;
  logic [3:0]  ls_sel_i = '0;
  logic [31:0] ls_data_i = '0;
  logic [31:0] ls_data_o;
  logic        ls_stallreq_o;
  logic        bus_cyc_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_data_o;
  logic [31:0] bus_data_i = '0;
  logic        bus_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .if_ce_i       (if_ce_i),
    .if_addr_i     (if_addr_i),
    .if_data_o     (if_data_o),
    .if_stallreq_o (if_stallreq_o),
    .ls_ce_i       (ls_ce_i),
    .ls_we_i       (ls_we_i),
    .ls_addr_i     (ls_addr_i),
    .ls_sel_i      (ls_sel_i),
    .ls_data_i     (ls_data_i),
    .ls_data_o     (ls_data_o),
    .ls_stallreq_o (ls_stallreq_o),
    .bus_cyc_o     (bus_cyc_o),
    .bus_we_o      (bus_we_o),
    .bus_addr_o    (bus_addr_o),
    .bus_sel_o     (bus_sel_o),
    .bus_data_o    (bus_data_o),
    .bus_data_i    (bus_data_i),
    .bus_ack_i     (bus_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    nedge();
    #1;
    chk("rst_cyc",  bus_cyc_o, 0);
    chk("rst_we",   bus_we_o, 0);
    chk("rst_addr", bus_addr_o, 0);
    chk("rst_sel",  bus_sel_o, 0);
    chk("rst_wdat", bus_data_o, 0);
    chk("rst_ifd",  if_data_o, 0);
    chk("rst_lsd",  ls_data_o, 0);
    rst = 1'b0;

    // ---------------- LS load, zero-wait slave ----------------
    nedge();
    ls_ce_i = 1; ls_we_i = 0; ls_addr_i = 32'h100; ls_sel_i = 4'b1111;
    #1;
    chk("ld_stall_c0", ls_stallreq_o, 1);
    chk("ld_cyc_c0",   bus_cyc_o, 0);
    nedge();
    bus_ack_i = 1; bus_data_i = 32'hDEADBEEF;
    #1;
    chk("ld_cyc_c1",   bus_cyc_o, 1);
    chk("ld_addr_c1",  bus_addr_o, 32'h100);
    chk("ld_we_c1",    bus_we_o, 0);
    chk("ld_sel_c1",   bus_sel_o, 4'b1111);
    chk("ld_stall_c1", ls_stallreq_o, 1);
    nedge();
    bus_ack_i = 0; bus_data_i = 32'h0;
    #1;
    chk("ld_stall_c2", ls_stallreq_o, 0);
    chk("ld_data_c2",  ls_data_o, 32'hDEADBEEF);
    chk("ld_cyc_c2",   bus_cyc_o, 0);
    ls_ce_i = 0;
    nedge();
    #1;
    chk("ld_cyc_c3",   bus_cyc_o, 0);
    chk("ld_hold_c3",  ls_data_o, 32'hDEADBEEF);

    // ---------------- simultaneous store + fetch ----------------
    nedge();
    if_ce_i = 1; if_addr_i = 32'h300;
    ls_ce_i = 1; ls_we_i = 1; ls_addr_i = 32'h204; ls_sel_i = 4'b0100; ls_data_i = 32'h12345678;
    #1;
    chk("sim_ifst_c0", if_stallreq_o, 1);
    chk("sim_lsst_c0", ls_stallreq_o, 1);
    nedge();
    #1;
    chk("sim_cyc_c1",  bus_cyc_o, 1);
    chk("sim_we_c1",   bus_we_o, 1);
    chk("sim_addr_c1", bus_addr_o, 32'h204);
    chk("sim_sel_c1",  bus_sel_o, 4'b0100);
    chk("sim_wd_c1",   bus_data_o, 32'h12345678);
    chk("sim_ifst_c1", if_stallreq_o, 1);
    bus_ack_i = 1; bus_data_i = 32'hAAAAAAAA;
    nedge();
    bus_ack_i = 0;
    #1;
    chk("sim_cyc_c2",  bus_cyc_o, 0);
    chk("sim_lsst_c2", ls_stallreq_o, 0);
    chk("sim_lsd_c2",  ls_data_o, 32'hDEADBEEF);  // store captures nothing
    chk("sim_ifst_c2", if_stallreq_o, 1);
    ls_ce_i = 0; ls_we_i = 0;

    // ---------------- fetch with 5 wait states ----------------
    for (int i = 0; i < 5; i++) begin
      nedge();
      #1;
      chk("ws_cyc",  bus_cyc_o, 1);
      chk("ws_addr", bus_addr_o, 32'h300);
      chk("ws_we",   bus_we_o, 0);
      chk("ws_sel",  bus_sel_o, 4'b1111);
      chk("ws_ifst", if_stallreq_o, 1);
    end
    nedge();
    bus_ack_i = 1; bus_data_i = 32'hCAFEF00D;
    #1;
    chk("ws_cyc_ack", bus_cyc_o, 1);
    nedge();
    bus_ack_i = 0; bus_data_i = 32'h99999999;
    #1;
    chk("ws_ifd",  if_data_o, 32'hCAFEF00D);
    chk("ws_ifst", if_stallreq_o, 0);
    chk("ws_cyc",  bus_cyc_o, 0);
    if_ce_i = 0;
    nedge();
    #1;
    chk("ws_single_cap", if_data_o, 32'hCAFEF00D);
    chk("ws_no_reissue", bus_cyc_o, 0);

    // ---------------- load while mem stage held ----------------
    nedge();
    stall_i = 6'b010000;
    ls_ce_i = 1; ls_we_i = 0; ls_addr_i = 32'h180; ls_sel_i = 4'b1111;
    nedge();
    bus_ack_i = 1; bus_data_i = 32'h5555AAAA;
    #1;
    chk("hold_cyc", bus_cyc_o, 1);
    for (int i = 0; i < 3; i++) begin
      nedge();
      bus_ack_i = 0; bus_data_i = 32'h0;
      #1;
      chk("hold_lsst", ls_stallreq_o, 0);
      chk("hold_lsd",  ls_data_o, 32'h5555AAAA);
      chk("hold_cyc",  bus_cyc_o, 0);
    end
    stall_i = 6'b000000;
    nedge();
    #1;
    chk("rel_lsst", ls_stallreq_o, 1);   // valid cleared after release
    chk("rel_cyc",  bus_cyc_o, 0);
    chk("rel_lsd",  ls_data_o, 32'h5555AAAA);
    ls_ce_i = 0;
    nedge();
    #1;
    chk("rel_cyc2", bus_cyc_o, 0);

    // ---------------- flush during fetch ----------------
    nedge();
    if_ce_i = 1; if_addr_i = 32'h380;
    nedge();
    #1;
    chk("fl_cyc_c1",  bus_cyc_o, 1);
    chk("fl_addr_c1", bus_addr_o, 32'h380);
    flush_i = 1;
    nedge();
    flush_i = 0; if_addr_i = 32'h400;
    #1;
    chk("fl_cyc_c2",  bus_cyc_o, 1);
    chk("fl_addr_c2", bus_addr_o, 32'h380);
    bus_ack_i = 1; bus_data_i = 32'h11111111;
    nedge();
    bus_ack_i = 0; bus_data_i = 32'h0;
    #1;
    chk("fl_cyc_c3",  bus_cyc_o, 0);
    chk("fl_ifst_c3", if_stallreq_o, 1);
    chk("fl_ifd_c3",  if_data_o, 32'hCAFEF00D);
    nedge();
    #1;
    chk("fl_cyc_c4",  bus_cyc_o, 1);
    chk("fl_addr_c4", bus_addr_o, 32'h400);
    bus_ack_i = 1; bus_data_i = 32'h22222222;
    nedge();
    bus_ack_i = 0; bus_data_i = 32'h0;
    #1;
    chk("fl_ifd_c5",  if_data_o, 32'h22222222);
    chk("fl_ifst_c5", if_stallreq_o, 0);
    if_ce_i = 0;

    // ---------------- async reset mid LS transfer ----------------
    nedge();
    ls_ce_i = 1; ls_we_i = 1; ls_addr_i = 32'h40; ls_sel_i = 4'b0011; ls_data_i = 32'h0BADF00D;
    nedge();
    #1;
    chk("ar_cyc_pre", bus_cyc_o, 1);
    ls_ce_i = 0;
    rst = 1'b1;
    #1;
    chk("ar_cyc",  bus_cyc_o, 0);
    chk("ar_we",   bus_we_o, 0);
    chk("ar_addr", bus_addr_o, 0);
    chk("ar_sel",  bus_sel_o, 0);
    chk("ar_wdat", bus_data_o, 0);
    chk("ar_ifd",  if_data_o, 0);
    chk("ar_lsd",  ls_data_o, 0);
    chk("ar_lsst", ls_stallreq_o, 0);
    chk("ar_ifst", if_stallreq_o, 0);
    nedge();
    rst = 1'b0;

    // ---------------- ack in IDLE is ignored ----------------
    nedge();
    bus_ack_i = 1; bus_data_i = 32'h77777777;
    nedge();
    bus_ack_i = 0;
    #1;
    chk("idle_ack_cyc", bus_cyc_o, 0);
    chk("idle_ack_lsd", ls_data_o, 0);
    chk("idle_ack_ifd", if_data_o, 0);
    ls_ce_i = 1; ls_we_i = 0;
    #1;
    chk("idle_ack_lsst", ls_stallreq_o, 1);  // no phantom valid
    ls_ce_i = 0;

    nedge();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bus_arbiter
`default_nettype wire
